// File: rtl/math_result_buffer_pkg.sv
// Shared types and helpers for the math result buffer: default widths, the stored
// entry layout and the occupancy counter width.
package math_result_buffer_pkg;

  localparam int unsigned MrbW    = 32;
  localparam int unsigned MrbSeqW = 8;

  typedef struct packed {
    logic [MrbW-1:0]    q;
    logic               rmd;
    logic [MrbSeqW-1:0] seq;
  } mrb_entry_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned mrb_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/math_result_fifo_mem.sv
// Depth x Width register array with one synchronous write port and one
// asynchronous read port.
module math_result_fifo_mem #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 41,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // No reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/math_result_buffer.sv
// Captures one-cycle result pulses from the math expression unit into a small tagged
// FIFO and presents them first-word-fall-through over a valid/ready handshake.
module math_result_buffer
  import math_result_buffer_pkg::*;
#(
  parameter int unsigned W     = MrbW,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = MrbSeqW,
  localparam int unsigned CntW = mrb_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_q,
  input  logic             in_rmd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_q,
  output logic             out_rmd,
  output logic [SEQ_W-1:0] out_seq,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             overflow,
  input  logic             ovf_clear
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef struct packed {
    logic [W-1:0]     q;
    logic             rmd;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             valid_q, valid_d, full_q, full_d, ovf_q, ovf_d;
  entry_t           head_q, head_d, wr_entry, rd_entry;
  logic             push, pop, drop;

  always_comb begin
    pop      = valid_q & out_ready;
    push     = in_valid & (~full_q | pop);
    drop     = in_valid & ~push;
    wr_entry = '{q: in_q, rmd: in_rmd, seq: seq_q};

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    seq_d    = push ? seq_q + SEQ_W'(1)   : seq_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
    full_d  = (count_d == CntW'(DEPTH));
    ovf_d   = drop | (ovf_q & ~ovf_clear);

    // New head is either still in the array or being written this very cycle
    // (buffer empty after any pop); otherwise the last head is held.
    head_d = head_q;
    if (valid_d) begin
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? wr_entry : rd_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  math_result_fifo_mem #(
    .Depth (DEPTH),
    .Width ($bits(entry_t))
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_d),
    .rdata_o (rd_entry)
  );

  assign out_valid = valid_q;
  assign out_q     = head_q.q;
  assign out_rmd   = head_q.rmd;
  assign out_seq   = head_q.seq;
  assign count     = count_q;
  assign full      = full_q;
  assign overflow  = ovf_q;

endmodule
